// File: rtl/fifo_burst_reader_pkg.sv
// Shared types and helpers for the receiver-side fifo burst drain engine.
package fifo_burst_reader_pkg;

  // Drain engine control states.
  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  // Number of bits needed to hold every value in 0..max_value (at least one bit).
  function automatic int count_width(input int max_value);
    if (max_value < 1) begin
      return 1;
    end else begin
      return $clog2(max_value + 1);
    end
  endfunction

endpackage

// File: rtl/fifo_burst_reader_flush_timer.sv
// Idle timer that flags when a partial burst has lingered long enough to be flushed.
// With FLUSH_TIMEOUT == 0 the timer does not exist and never expires.
module flush_timer
  import fifo_burst_reader_pkg::*;
#(
  parameter int FLUSH_TIMEOUT = 16
) (
  input  logic clock,
  input  logic reset,
  input  logic enable,
  input  logic clear,
  output logic expired
);

  if (FLUSH_TIMEOUT == 0) begin : g_disabled
    logic unused_inputs_s;
    assign unused_inputs_s = clock ^ reset ^ enable ^ clear;
    assign expired = 1'b0;
  end else begin : g_enabled
    localparam int TW = count_width(FLUSH_TIMEOUT);
    localparam logic [TW-1:0] LAST_COUNT = TW'(FLUSH_TIMEOUT - 1);

    logic [TW-1:0] timer_r;

    // Count qualifying idle cycles; the count parks at its last value so it cannot wrap.
    always_ff @(posedge clock) begin
      if (reset) begin
        timer_r <= '0;
      end else if (clear) begin
        timer_r <= '0;
      end else if (enable && (timer_r != LAST_COUNT)) begin
        timer_r <= timer_r + {{(TW-1){1'b0}}, 1'b1};
      end else begin
        timer_r <= timer_r;
      end
    end

    assign expired = (timer_r == LAST_COUNT);
  end

endmodule

// File: rtl/fifo_burst_reader.sv
// Receiver-domain drain engine: pops the dual-clock fifo in bursts through its
// first-word-fall-through acknowledge port and re-times the words onto a
// registered valid/ready stream carrying first/last burst framing.
module fifo_burst_reader
  import fifo_burst_reader_pkg::*;
#(
  parameter int DATA_WIDTH    = 8,
  parameter int POINTER_WIDTH = 4,
  parameter int BURST_LENGTH  = 4,
  parameter int FLUSH_TIMEOUT = 16
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [POINTER_WIDTH-1:0] fifo_used,
  output logic                     fifo_acknowledge,
  input  logic [DATA_WIDTH-1:0]    fifo_data,
  output logic                     stream_valid,
  input  logic                     stream_ready,
  output logic [DATA_WIDTH-1:0]    stream_data,
  output logic                     stream_first,
  output logic                     stream_last
);

  // A partial burst is always shorter than a full one, so this width covers both.
  localparam int CW = count_width(BURST_LENGTH);
  localparam logic [CW-1:0]            FULL_SIZE = CW'(BURST_LENGTH);
  localparam logic [CW-1:0]            ONE       = CW'(1);
  localparam logic [POINTER_WIDTH-1:0] FULL_USED = POINTER_WIDTH'(BURST_LENGTH);

  if ((BURST_LENGTH < 1) || (BURST_LENGTH > ((2 ** POINTER_WIDTH) - 1))) begin : g_bad_burst_length
    $error("fifo_burst_reader: BURST_LENGTH must lie in 1 .. 2**POINTER_WIDTH-1");
  end

  state_t        state_r;
  logic [CW-1:0] remaining_r;
  logic [CW-1:0] size_r;

  logic occupied_s;
  logic above_threshold_s;
  logic start_full_s;
  logic start_flush_s;
  logic load_s;
  logic timer_enable_s;
  logic timer_clear_s;
  logic timer_expired_s;

  // Burst start conditions, the pop/load strobe and timer control.
  always_comb begin
    occupied_s        = (fifo_used != '0);
    above_threshold_s = (fifo_used >= FULL_USED);
    start_full_s      = (state_r == IDLE) && above_threshold_s;
    start_flush_s     = (state_r == IDLE) && !above_threshold_s && timer_expired_s && occupied_s;
    // The occupancy guard keeps the fifo safe even if another consumer ever appears.
    load_s            = !reset && (state_r == BURST) && occupied_s && (!stream_valid || stream_ready);
    timer_enable_s    = (state_r == IDLE) && occupied_s && !above_threshold_s;
    timer_clear_s     = !occupied_s || start_full_s || start_flush_s;
  end

  assign fifo_acknowledge = load_s;

  flush_timer #(
    .FLUSH_TIMEOUT(FLUSH_TIMEOUT)
  ) u_flush_timer (
    .clock  (clock),
    .reset  (reset),
    .enable (timer_enable_s),
    .clear  (timer_clear_s),
    .expired(timer_expired_s)
  );

  // Burst sequencing: pick the burst size at start and count words down as they are popped.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r     <= IDLE;
      remaining_r <= '0;
      size_r      <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          if (start_full_s) begin
            state_r     <= BURST;
            remaining_r <= FULL_SIZE;
            size_r      <= FULL_SIZE;
          end else if (start_flush_s) begin
            state_r     <= BURST;
            remaining_r <= fifo_used[CW-1:0];
            size_r      <= fifo_used[CW-1:0];
          end else begin
            state_r     <= IDLE;
          end
        end
        BURST: begin
          if (load_s) begin
            remaining_r <= remaining_r - ONE;
            if (remaining_r == ONE) begin
              state_r <= IDLE;
            end else begin
              state_r <= BURST;
            end
          end else begin
            state_r <= BURST;
          end
        end
        default: begin
          state_r     <= IDLE;
          remaining_r <= '0;
          size_r      <= '0;
        end
      endcase
    end
  end

  // Output stage: capture the popped word with its framing, hold it under backpressure.
  always_ff @(posedge clock) begin
    if (reset) begin
      stream_valid <= 1'b0;
      stream_data  <= '0;
      stream_first <= 1'b0;
      stream_last  <= 1'b0;
    end else if (load_s) begin
      stream_valid <= 1'b1;
      stream_data  <= fifo_data;
      stream_first <= (remaining_r == size_r);
      stream_last  <= (remaining_r == ONE);
    end else if (stream_valid && stream_ready) begin
      stream_valid <= 1'b0;
    end else begin
      stream_valid <= stream_valid;
    end
  end

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Scoreboard bench for fifo_burst_reader: a queue models the fifo, a cycle
// model of the burst rules predicts acknowledges and framed beats, and a
// separate monitor compares every stream handshake against the predictions.
module tb_fifo_burst_reader;

  localparam int DW = 8;
  localparam int PW = 4;
  localparam int BL = 4;
  localparam int TO = 16;
  localparam int FIFO_DEPTH = (2 ** PW) - 1;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          first;
    logic          last;
  } beat_t;

  logic          clock = 1'b0;
  logic          reset;
  logic [PW-1:0] fifo_used;
  logic          fifo_acknowledge;
  logic [DW-1:0] fifo_data;
  logic          stream_valid;
  logic          stream_ready;
  logic [DW-1:0] stream_data;
  logic          stream_first;
  logic          stream_last;

  // Second instance with flushing disabled, parked on a partial fifo.
  logic [PW-1:0] nf_used;
  logic          nf_ack;
  logic [DW-1:0] nf_data;
  logic          nf_valid;
  logic          nf_ready;
  logic [DW-1:0] nf_stream_data;
  logic          nf_first;
  logic          nf_last;

  logic [DW-1:0] fq[$];
  beat_t         expq[$];
  int            n_checks = 0;
  int            n_pass = 0;
  logic          ack_obs = 1'b0;
  int            pops = 0;
  int            seq = 0;
  int            m_left = 0;
  int            m_size = 0;
  int            m_run = 0;
  bit            m_pending = 1'b0;

  always #5 clock = ~clock;

  fifo_burst_reader #(
    .DATA_WIDTH(DW), .POINTER_WIDTH(PW), .BURST_LENGTH(BL), .FLUSH_TIMEOUT(TO)
  ) dut (
    .clock(clock), .reset(reset), .fifo_used(fifo_used), .fifo_acknowledge(fifo_acknowledge),
    .fifo_data(fifo_data), .stream_valid(stream_valid), .stream_ready(stream_ready),
    .stream_data(stream_data), .stream_first(stream_first), .stream_last(stream_last)
  );

  fifo_burst_reader #(
    .DATA_WIDTH(DW), .POINTER_WIDTH(PW), .BURST_LENGTH(BL), .FLUSH_TIMEOUT(0)
  ) dut_noflush (
    .clock(clock), .reset(reset), .fifo_used(nf_used), .fifo_acknowledge(nf_ack),
    .fifo_data(nf_data), .stream_valid(nf_valid), .stream_ready(nf_ready),
    .stream_data(nf_stream_data), .stream_first(nf_first), .stream_last(nf_last)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic drive_pins();
    fifo_used = PW'(fq.size());
    if (fq.size() > 0) fifo_data = fq[0];
    else fifo_data = '0;
  endtask

  task automatic push_word();
    if (fq.size() < FIFO_DEPTH) begin
      fq.push_back(DW'(seq));
      seq++;
    end
    drive_pins();
  endtask

  // Advance one clock; apply the pop the DUT performed at that edge.
  task automatic next_cycle();
    @(posedge clock);
    #1;
    if (ack_obs) begin
      void'(fq.pop_front());
      pops++;
    end
    drive_pins();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) next_cycle();
  endtask

  task automatic check_reset_outputs();
    @(negedge clock);
    check("rst_valid", stream_valid, 1'b0);
    check("rst_first", stream_first, 1'b0);
    check("rst_last", stream_last, 1'b0);
    check("rst_data", stream_data, 8'h00);
    check("rst_ack", fifo_acknowledge, 1'b0);
  endtask

  // Reference model: burst rules evaluated once per cycle on the stable inputs.
  initial begin
    forever begin
      int  occ;
      bit  was_idle;
      bit  exp_ack;
      @(negedge clock);
      #1;
      occ = fq.size();
      check("noflush_ack", nf_ack, 1'b0);
      check("noflush_valid", nf_valid, 1'b0);
      if (reset) begin
        check("ack_in_reset", fifo_acknowledge, 1'b0);
        m_left = 0;
        m_size = 0;
        m_run = 0;
        m_pending = 1'b0;
        expq.delete();
        ack_obs = 1'b0;
      end else begin
        was_idle = (m_left == 0);
        exp_ack = (m_left > 0) && (occ > 0) && (!m_pending || stream_ready);
        check("ack", fifo_acknowledge, exp_ack);
        check("valid", stream_valid, m_pending);
        ack_obs = fifo_acknowledge;
        if (exp_ack) begin
          expq.push_back('{data: fq[0], first: (m_left == m_size), last: (m_left == 1)});
          m_left--;
          m_pending = 1'b1;
        end else if (stream_ready) begin
          m_pending = 1'b0;
        end
        if (occ == 0) m_run = 0;
        if (was_idle) begin
          if (occ >= BL) begin
            m_left = BL;
            m_size = BL;
            m_run = 0;
          end else if (occ > 0) begin
            if ((TO != 0) && (m_run + 1 == TO)) begin
              m_left = occ;
              m_size = occ;
              m_run = 0;
            end else begin
              m_run++;
            end
          end
        end
      end
    end
  end

  // Monitor: compare each handshake with the scoreboard and check hold under backpressure.
  initial begin
    logic  pv;
    logic  pr;
    logic  prst;
    beat_t pb;
    beat_t exp_b;
    pv = 1'b0;
    pr = 1'b0;
    prst = 1'b1;
    pb = '0;
    forever begin
      @(negedge clock);
      if (!prst && pv && !pr) begin
        check("hold_valid", stream_valid, 1'b1);
        check("hold_beat", {stream_data, stream_first, stream_last}, pb);
      end
      if (stream_valid && stream_ready) begin
        check("beat_expected", 32'(expq.size() > 0), 1'b1);
        if (expq.size() > 0) begin
          exp_b = expq.pop_front();
          check("beat", {stream_data, stream_first, stream_last}, exp_b);
        end
      end
      pv = stream_valid;
      pr = stream_ready;
      prst = reset;
      pb = '{data: stream_data, first: stream_first, last: stream_last};
    end
  end

  // Stimulus.
  initial begin
    int p0;
    reset = 1'b1;
    stream_ready = 1'b1;
    nf_used = 4'd2;
    nf_data = 8'h5A;
    nf_ready = 1'b1;
    drive_pins();
    run(3);
    check_reset_outputs();
    reset = 1'b0;
    run(1);

    // Full burst, continuous ready.
    repeat (4) push_word();
    run(12);

    // Backpressure in the middle of a burst.
    repeat (4) push_word();
    for (int i = 0; i < 16; i++) begin
      next_cycle();
      stream_ready = !(i >= 3 && i < 6);
    end
    stream_ready = 1'b1;

    // Partial burst drained by the flush timer.
    repeat (2) push_word();
    run(25);

    // Two back-to-back bursts.
    repeat (8) push_word();
    run(14);

    // Reset after two of four words have been popped.
    repeat (4) push_word();
    p0 = pops;
    for (int k = 0; k < 30 && pops < p0 + 2; k++) next_cycle();
    check("reset_wait", 32'(pops >= p0 + 2), 1'b1);
    reset = 1'b1;
    next_cycle();
    check_reset_outputs();
    reset = 1'b0;
    repeat (2) push_word();
    run(12);

    // Full fifo: three full bursts then a flushed remainder.
    while (fq.size() < FIFO_DEPTH) push_word();
    run(80);

    // Random traffic and random backpressure.
    for (int i = 0; i < 400; i++) begin
      next_cycle();
      if ($urandom_range(0, 3) == 0) push_word();
      stream_ready = ($urandom_range(0, 3) != 0);
    end

    // Drain everything.
    stream_ready = 1'b1;
    for (int k = 0; k < 300 && (fq.size() != 0 || expq.size() != 0 || m_left != 0); k++) next_cycle();
    run(3);
    check("fifo_drained", fq.size(), 0);
    check("scoreboard_empty", expq.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
